// File: rtl/scan_chain_driver_pkg.sv
// scan_pkg: shared state encoding and defaults for the scan chain driver
package scan_pkg;
    typedef enum logic [2:0] {IDLE, SHIFT_IN, LATCH, CAPTURE, SHIFT_OUT, HOLD} state_t;
    localparam int DEF_WIDTH = 8;
    localparam int DEF_CLK_DIV = 2;
    function automatic int cnt_w(input int w);
        return $clog2(w + 1);
    endfunction
endpackage

// File: rtl/scan_chain_driver_clk_gen.sv
// scan_clk_gen: divides clk into a 50% duty scan clock with rise/fall strobes
module scan_clk_gen
    import scan_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic scan_clk,
    output logic rise_stb,
    output logic fall_stb
);
    localparam int CW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    logic [CW-1:0] cnt;
    logic wrap;
    assign wrap = en && cnt == CW'(CLK_DIV - 1);
    // strobes mark the clk edge at which scan_clk is about to toggle
    assign rise_stb = wrap && !scan_clk;
    assign fall_stb = wrap && scan_clk;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            scan_clk <= 1'b0;
        end else if (!en) begin
            cnt <= '0;
            scan_clk <= 1'b0;
        end else begin
            cnt <= wrap ? '0 : cnt + 1'b1;
            scan_clk <= wrap ? ~scan_clk : scan_clk;
        end
    end
endmodule

// File: rtl/scan_chain_driver.sv
// scan_chain_driver: shifts a vector into a scan chain, latches, captures and
// shifts the design outputs back out as a parallel word
module scan_chain_driver
    import scan_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             scan_clk_out,
    output logic             scan_data_out,
    output logic             scan_select,
    output logic             scan_latch_en,
    input  logic             scan_data_in,
    output logic             busy
);
    localparam int BW = cnt_w(WIDTH);
    state_t state;
    logic [WIDTH-1:0] sr;
    logic [BW-1:0] bits;
    logic rise, fall, last, clk_en;
    assign last = bits == BW'(WIDTH - 1);
    assign clk_en = state inside {SHIFT_IN, CAPTURE, SHIFT_OUT};

    scan_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
        .clk(clk),
        .rst_n(rst_n),
        .en(clk_en),
        .scan_clk(scan_clk_out),
        .rise_stb(rise),
        .fall_stb(fall)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            sr <= '0;
            bits <= '0;
            in_ready <= 1'b1;
            busy <= 1'b0;
            out_valid <= 1'b0;
            out_data <= '0;
            scan_data_out <= 1'b0;
            scan_select <= 1'b0;
            scan_latch_en <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    state <= SHIFT_IN;
                    scan_data_out <= in_data[WIDTH-1];
                    sr <= in_data << 1;
                    bits <= '0;
                    in_ready <= 1'b0;
                    busy <= 1'b1;
                end
                // next bit goes out as scan_clk falls, i.e. at the start of each low half
                SHIFT_IN: if (fall) begin
                    if (last) begin
                        state <= LATCH;
                        scan_data_out <= 1'b0;
                        scan_latch_en <= 1'b1;
                    end else begin
                        scan_data_out <= sr[WIDTH-1];
                        sr <= sr << 1;
                        bits <= bits + 1'b1;
                    end
                end
                LATCH: begin
                    state <= CAPTURE;
                    scan_latch_en <= 1'b0;
                    scan_select <= 1'b1;
                end
                CAPTURE: if (fall) begin
                    state <= SHIFT_OUT;
                    scan_select <= 1'b0;
                    bits <= '0;
                end
                // chain tail is sampled before the rising scan_clk shifts it
                SHIFT_OUT: begin
                    if (rise) out_data <= (out_data << 1) | WIDTH'(scan_data_in);
                    if (fall) begin
                        if (last) begin
                            state <= HOLD;
                            out_valid <= 1'b1;
                        end else begin
                            bits <= bits + 1'b1;
                        end
                    end
                end
                HOLD: if (out_ready) begin
                    state <= IDLE;
                    out_valid <= 1'b0;
                    in_ready <= 1'b1;
                    busy <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_scan_chain_driver.sv
// tb_scan_chain_driver: loopback bench for two driver configurations (8/2 and 4/1)
module tb_scan_chain_driver;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    int checks = 0, failures = 0;

    logic [7:0] in_data0 = '0, out_data0, ch0 = '0, di0 = '0;
    logic in_valid0 = 1'b0, out_ready0 = 1'b0;
    logic in_ready0, out_valid0, sclk0, sdo0, ssel0, slat0, sdi0, busy0;
    logic [3:0] in_data1 = '0, out_data1, ch1 = '0, di1 = '0;
    logic in_valid1 = 1'b0, out_ready1 = 1'b0;
    logic in_ready1, out_valid1, sclk1, sdo1, ssel1, slat1, sdi1, busy1;
    int nr0 = 0, nl0 = 0, ns0 = 0, nr1 = 0, nl1 = 0, ns1 = 0;

    scan_chain_driver #(.WIDTH(8), .CLK_DIV(2)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data0), .in_valid(in_valid0), .in_ready(in_ready0),
        .out_data(out_data0), .out_valid(out_valid0), .out_ready(out_ready0), .scan_clk_out(sclk0),
        .scan_data_out(sdo0), .scan_select(ssel0), .scan_latch_en(slat0), .scan_data_in(sdi0), .busy(busy0)
    );
    scan_chain_driver #(.WIDTH(4), .CLK_DIV(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data1), .in_valid(in_valid1), .in_ready(in_ready1),
        .out_data(out_data1), .out_valid(out_valid1), .out_ready(out_ready1), .scan_clk_out(sclk1),
        .scan_data_out(sdo1), .scan_select(ssel1), .scan_latch_en(slat1), .scan_data_in(sdi1), .busy(busy1)
    );

    // model chains: shift on scan clock, capture inverted design inputs when selected
    always @(posedge sclk0) begin
        ch0 <= ssel0 ? ~di0 : {ch0[6:0], sdo0};
        nr0 <= nr0 + 1;
    end
    always @(posedge sclk1) begin
        ch1 <= ssel1 ? ~di1 : {ch1[2:0], sdo1};
        nr1 <= nr1 + 1;
    end
    always @(posedge clk) begin
        if (slat0) di0 <= ch0;
        if (slat1) di1 <= ch1;
        if (slat0) nl0 <= nl0 + 1;
        if (slat1) nl1 <= nl1 + 1;
        if (ssel0) ns0 <= ns0 + 1;
        if (ssel1) ns1 <= ns1 + 1;
    end
    assign sdi0 = ch0[7];
    assign sdi1 = ch1[3];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] st(input int s);
        return s != 0 ? {in_ready1, out_valid1, busy1, sclk1, sdo1, ssel1, slat1}
                      : {in_ready0, out_valid0, busy0, sclk0, sdo0, ssel0, slat0};
    endfunction
    function automatic logic [7:0] odata(input int s);
        return s != 0 ? {4'h0, out_data1} : out_data0;
    endfunction
    function automatic logic [7:0] dins(input int s);
        return s != 0 ? {4'h0, di1} : di0;
    endfunction
    function automatic int nrise(input int s);
        return s != 0 ? nr1 : nr0;
    endfunction
    function automatic int nlat(input int s);
        return s != 0 ? nl1 : nl0;
    endfunction
    function automatic int nsel(input int s);
        return s != 0 ? ns1 : ns0;
    endfunction

    task automatic drive(input int s, input logic v, input logic [7:0] d, input logic r);
        if (s == 0) begin
            in_valid0 = v; in_data0 = d; out_ready0 = r;
        end else begin
            in_valid1 = v; in_data1 = d[3:0]; out_ready1 = r;
        end
    endtask

    task automatic txn(input int s, input logic [7:0] d, input int hold_req, input logic rdy_hi);
        int w, dv, hold, k, r0, l0, s0;
        logic ok;
        logic [7:0] m, od;
        w = s != 0 ? 4 : 8;
        dv = s != 0 ? 1 : 2;
        m = s != 0 ? 8'h0f : 8'hff;
        hold = rdy_hi ? 0 : hold_req;
        @(negedge clk);
        check("idle_ready", 32'(st(s)[6]), 32'd1);
        drive(s, 1'b1, d, rdy_hi);
        r0 = nrise(s); l0 = nlat(s); s0 = nsel(s);
        @(posedge clk);
        @(negedge clk);
        drive(s, 1'b0, d, rdy_hi);
        k = 0;
        ok = 1'b1;
        while (st(s)[5] !== 1'b1 && k < 1000) begin
            if (k < 2 * dv * w && st(s)[3] !== 1'((k / dv) % 2)) ok = 1'b0;
            @(negedge clk);
            k++;
        end
        check("latency", 32'(k + 1), 32'(2 + 2 * dv * (2 * w + 1)));
        check("sclk_wave", 32'(ok), 32'd1);
        check("out_data", 32'(odata(s)), 32'(~d & m));
        check("design_in", 32'(dins(s)), 32'(d & m));
        check("sclk_rises", 32'(nrise(s) - r0), 32'(2 * w + 1));
        check("latch_cycles", 32'(nlat(s) - l0), 32'd1);
        check("select_cycles", 32'(nsel(s) - s0), 32'(2 * dv));
        od = odata(s);
        ok = 1'b1;
        for (int i = 0; i < hold; i++) begin
            drive(s, 1'($urandom_range(0, 1)), 8'($urandom), 1'b0);
            @(negedge clk);
            if (odata(s) !== od || st(s) !== 7'b0110000) ok = 1'b0;
        end
        if (hold > 0) check("hold_stall", 32'(ok), 32'd1);
        drive(s, 1'b0, d, 1'b1);
        @(posedge clk);
        @(negedge clk);
        check("ready_after_hs", 32'(st(s)), 32'(7'b1000000));
        drive(s, 1'b0, d, 1'b0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_st0", 32'(st(0)), 32'(7'b1000000));
        check("rst_st1", 32'(st(1)), 32'(7'b1000000));
        check("rst_out0", 32'(out_data0), 32'd0);
        check("rst_out1", 32'(out_data1), 32'd0);
        rst_n = 1'b1;
        txn(0, 8'hA5, 20, 1'b0);
        // abort a transaction in SHIFT_OUT with an asynchronous reset
        @(negedge clk);
        drive(0, 1'b1, 8'h77, 1'b0);
        @(posedge clk);
        @(negedge clk);
        drive(0, 1'b0, 8'h77, 1'b0);
        repeat (50) @(negedge clk);
        #1 rst_n = 1'b0;
        #1 check("rst_midop", 32'({st(0), out_data0}), 32'({7'b1000000, 8'h00}));
        @(negedge clk);
        check("rst_held", 32'({st(0), out_data0}), 32'({7'b1000000, 8'h00}));
        rst_n = 1'b1;
        txn(0, 8'h3C, 3, 1'b0);
        txn(1, 8'h09, 2, 1'b0);
        txn(0, 8'h00, 0, 1'b1);
        txn(0, 8'hFF, 0, 1'b1);
        for (int i = 0; i < 6; i++)
            txn(i % 2, 8'($urandom), int'($urandom_range(0, 5)), 1'($urandom_range(0, 1)));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end
endmodule
